// File: rtl/dual_port_ram_ctrl.sv
// Two-port word RAM: port A read/write with byte enables, port B read-only.
// Each port runs its own req/ready/valid FSM; a clear engine zeroes the array after reset.
module dual_port_ram_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int BYTE_WIDTH    = 8,
  parameter int DEPTH         = 512,
  parameter int ADDRESS_WIDTH = 32,
  parameter int WAIT_STATES   = 1,
  localparam int NB           = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     a_req,
  input  logic                     a_we,
  input  logic [NB-1:0]            a_be,
  input  logic [ADDRESS_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0]    a_wdata,
  output logic                     a_ready,
  output logic                     a_valid,
  output logic                     a_err,
  output logic [DATA_WIDTH-1:0]    a_rdata,
  input  logic                     b_req,
  input  logic [ADDRESS_WIDTH-1:0] b_addr,
  output logic                     b_ready,
  output logic                     b_valid,
  output logic                     b_err,
  output logic [DATA_WIDTH-1:0]    b_rdata,
  output logic                     init_done
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {CLEAR, RUN} clr_t;
  typedef enum logic {P_IDLE, P_WAIT} port_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  clr_t             clr_state;
  logic [IDX_W-1:0] clr_cnt;
  logic             clr_last;

  port_t                         a_state, b_state;
  logic [3:0]                    a_cnt, b_cnt;
  logic                          a_we_q;
  logic [NB-1:0]                 a_be_q;
  logic [ADDRESS_WIDTH-1:0]      a_addr_q, b_addr_q;
  logic [NB-1:0][BYTE_WIDTH-1:0] a_wdata_q, a_old, a_merged;
  logic [DATA_WIDTH-1:0]         b_old;
  logic [IDX_W-1:0]              a_idx, b_idx;
  logic                          a_oor, b_oor, a_rsp, b_rsp, a_wr;

  assign clr_last = (clr_state == CLEAR) && (clr_cnt == IDX_W'(DEPTH - 1));

  assign a_idx = a_addr_q[IDX_W-1:0];
  assign b_idx = b_addr_q[IDX_W-1:0];
  assign a_oor = (a_addr_q >= ADDRESS_WIDTH'(DEPTH));
  assign b_oor = (b_addr_q >= ADDRESS_WIDTH'(DEPTH));
  assign a_old = mem[a_idx];
  assign b_old = mem[b_idx];
  assign a_rsp = (a_state == P_WAIT) && (a_cnt == '0);
  assign b_rsp = (b_state == P_WAIT) && (b_cnt == '0);
  assign a_wr  = a_rsp && a_we_q && !a_oor;

  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign a_merged[i] = a_be_q[i] ? a_wdata_q[i] : a_old[i];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_state <= CLEAR;
      clr_cnt   <= '0;
      init_done <= 1'b0;
    end else if (clr_state == CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_last) begin
        clr_state <= RUN;
        init_done <= 1'b1;
      end
    end
  end

  // B reads use the pre-edge array contents, so a same-edge A write is not visible to B.
  always_ff @(posedge clk) begin
    if (clr_state == CLEAR) mem[clr_cnt] <= '0;
    else if (a_wr)          mem[a_idx]   <= a_merged;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_state   <= P_IDLE;
      a_cnt     <= '0;
      a_ready   <= 1'b0;
      a_valid   <= 1'b0;
      a_err     <= 1'b0;
      a_rdata   <= '0;
      a_we_q    <= 1'b0;
      a_be_q    <= '0;
      a_addr_q  <= '0;
      a_wdata_q <= '0;
    end else begin
      a_valid <= 1'b0;
      case (a_state)
        P_IDLE: begin
          if (a_ready && a_req) begin
            a_we_q    <= a_we;
            a_be_q    <= a_be;
            a_addr_q  <= a_addr;
            a_wdata_q <= a_wdata;
            a_cnt     <= 4'(WAIT_STATES);
            a_ready   <= 1'b0;
            a_state   <= P_WAIT;
          end else if (clr_last) begin
            a_ready <= 1'b1;
          end
        end
        P_WAIT: begin
          if (a_rsp) begin
            a_valid <= 1'b1;
            a_ready <= 1'b1;
            a_err   <= a_oor;
            a_rdata <= a_oor ? '0 : (a_we_q ? a_merged : a_old);
            a_state <= P_IDLE;
          end else begin
            a_cnt <= a_cnt - 1'b1;
          end
        end
        default: a_state <= P_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      b_state  <= P_IDLE;
      b_cnt    <= '0;
      b_ready  <= 1'b0;
      b_valid  <= 1'b0;
      b_err    <= 1'b0;
      b_rdata  <= '0;
      b_addr_q <= '0;
    end else begin
      b_valid <= 1'b0;
      case (b_state)
        P_IDLE: begin
          if (b_ready && b_req) begin
            b_addr_q <= b_addr;
            b_cnt    <= 4'(WAIT_STATES);
            b_ready  <= 1'b0;
            b_state  <= P_WAIT;
          end else if (clr_last) begin
            b_ready <= 1'b1;
          end
        end
        P_WAIT: begin
          if (b_rsp) begin
            b_valid <= 1'b1;
            b_ready <= 1'b1;
            b_err   <= b_oor;
            b_rdata <= b_oor ? '0 : b_old;
            b_state <= P_IDLE;
          end else begin
            b_cnt <= b_cnt - 1'b1;
          end
        end
        default: b_state <= P_IDLE;
      endcase
    end
  end
endmodule

// File: doc/dual_port_ram_ctrl.md
Name: dual_port_ram_ctrl

Overview:
- Parametrised two-port word RAM with a request/ready/valid handshake.
- Port A is read/write with byte enables. Port B is read-only.
- Per-port latency is configurable through wait states; out-of-range accesses are flagged.
- A hardware clear engine zeroes the whole array after every reset. The CPU core and instruction fetch use this block instead of a free-running, unhandshaked RAM.

Parameters:
- DATA_WIDTH, 32, word width in bits.
- BYTE_WIDTH, 8, bits per byte lane; DATA_WIDTH must be a multiple of it. NB = DATA_WIDTH/BYTE_WIDTH.
- DEPTH, 512, number of words; word-addressed, valid addresses 0..DEPTH-1.
- ADDRESS_WIDTH, 32, width of the address ports.
- WAIT_STATES, 1, extra cycles between acceptance and response (0..15).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- a_req  in  1  port A request.
- a_we  in  1  port A write (1) / read (0).
- a_be  in  NB  port A byte enables, bit i enables lane i.
- a_addr  in  ADDRESS_WIDTH  port A word address.
- a_wdata  in  DATA_WIDTH  port A write data.
- a_ready  out  1  port A can accept a request.
- a_valid  out  1  port A response strobe, one cycle.
- a_err  out  1  port A out-of-range flag, qualified by a_valid.
- a_rdata  out  DATA_WIDTH  port A response data.
- b_req  in  1  port B read request.
- b_addr  in  ADDRESS_WIDTH  port B word address.
- b_ready  out  1  port B can accept a request.
- b_valid  out  1  port B response strobe.
- b_err  out  1  port B out-of-range flag.
- b_rdata  out  DATA_WIDTH  port B response data.
- init_done  out  1  clear engine finished; the RAM is usable.

Behaviour:
- reset=0 (asynchronous):
  - All outputs go to 0: ready, valid, err, rdata, init_done.
  - Both port FSMs go to IDLE; the clear FSM goes to CLEAR with its counter at 0.
  - In-flight transactions are dropped; no valid is issued for them.
- Clear FSM, CLEAR -> RUN:
  - In CLEAR, one word per cycle is written to 0 at addresses 0..DEPTH-1, for DEPTH edges after reset rises.
  - On the edge that writes DEPTH-1, the FSM moves to RUN.
  - init_done=1, a_ready=1 and b_ready=1 from that edge onward.
  - Requests during CLEAR are ignored; they are not queued.
- Port FSM, per port, states IDLE -> WAIT -> IDLE:
  - A request is accepted at an edge k where req=1 and ready=1.
  - At acceptance the block captures addr, plus we/be/wdata for port A; later input changes are irrelevant.
  - ready=0 from edge k.
  - A counter runs WAIT_STATES cycles. At edge k+1+WAIT_STATES: valid=1 for one cycle, rdata and err update, ready returns to 1.
  - The earliest next acceptance is edge k+2+WAIT_STATES, giving one transaction per WAIT_STATES+2 cycles.
  - rdata holds its value until the next response.
- Reads: rdata = memory[addr] sampled at the response edge.
- Writes (port A):
  - At the response edge, each lane i with a_be[i]=1 is replaced by wdata lane i; other lanes are unchanged.
  - a_rdata returns the merged new word.
  - a_be=0 leaves memory unchanged, returns the current word, and still pulses valid.
- Out of range (captured addr >= DEPTH): err=1 with valid, rdata=0, no memory write.
- Collision:
  - If the port B read and the port A write to the same address respond on the same edge, B returns the old word and A's write takes effect.
  - Non-colliding ports operate fully independently.
- Port independence: A and B have separate FSMs and may be mid-transaction simultaneously.
- Reset asserted mid-transaction or mid-CLEAR: the clear restarts from address 0; a pending write is not performed.

Test Plan:
- Clear engine:
  - Stimulus: DEPTH=16, WAIT_STATES=1. Release reset; hold a_req=1.
  - Required response: init_done and both ready rise exactly 16 edges after reset rises; no valid pulses before that.
  - Then a read of any of addresses 0..15 returns 0.
- Byte-enable write and latency:
  - Stimulus: write addr 3, wdata 0xAABBCCDD, be=1111. Then write addr 3, wdata 0x11223344, be=0101.
  - Required response: a_valid arrives 2 cycles after each acceptance.
  - A read of 3 returns 0xAA22CC44; a_ready is low during each wait.
- Collision:
  - Stimulus: addr 5 = 0x00000001. A writes 0xFFFFFFFF to addr 5 while B reads addr 5, both accepted on the same edge.
  - Required response: b_rdata=0x00000001. A subsequent B read returns 0xFFFFFFFF.
- Out of range:
  - Stimulus: A writes 0x12345678 to addr 16; B reads addr 40.
  - Required response: a_err=1 and b_err=1 with valid, rdata=0. All 16 words are unchanged.
- WAIT_STATES=0 throughput:
  - Stimulus: a_req held high with reads of addresses 0,1,2.
  - Required response: accepts on alternating edges; a valid follows 1 edge after each accept.
- Reset mid-operation:
  - Stimulus: assert reset=0 between acceptance and response of a write 0xDEADBEEF to addr 7.
  - Required response: all outputs go to 0 immediately; no valid is issued; the clear reruns; addr 7 reads 0.
